// File: rtl/video_pkg.sv
// Shared BT.656 definitions: XY byte layout, protection-bit function,
// decoder state encoding and default line geometry.
package video_pkg;

    localparam int H_ACTIVE_DEFAULT  = 720;
    localparam int MAX_LINES_DEFAULT = 1023;

    localparam int XY_ONE_BIT = 7;
    localparam int XY_F_BIT   = 6;
    localparam int XY_V_BIT   = 5;
    localparam int XY_H_BIT   = 4;

    typedef enum logic [1:0] {
        NOLOCK = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } dec_state_t;

    // Expected P3..P0 for a given F/V/H combination.
    function automatic logic [3:0] trs_protect(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/trs_detector.sv
// Spots the FF 00 00 preamble in a BT.656 byte stream and qualifies the XY byte
// that follows it. Outputs are combinational on the XY byte.
module trs_detector
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] td_data,
    output logic       trs_hit,
    output logic       trs_valid,
    output logic       f,
    output logic       v,
    output logic       h
);

    // Oldest byte in the top octet.
    logic [23:0] hist_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[15:0], td_data};
        end
    end

    assign trs_hit   = (hist_q == 24'hFF_0000);
    assign f         = td_data[XY_F_BIT];
    assign v         = td_data[XY_V_BIT];
    assign h         = td_data[XY_H_BIT];
    assign trs_valid = trs_hit && td_data[XY_ONE_BIT] && (td_data[3:0] == trs_protect(f, v, h));

endmodule

// File: rtl/itu656_decoder.sv
// BT.656 receiver: tracks TRS-derived line/field state and turns the
// Cb Y Cr Y byte stream into one registered 4:2:2 pixel per Y byte.
module itu656_decoder
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEFAULT,
    parameter int MAX_LINES = MAX_LINES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] td_data,
    output logic       pix_valid,
    output logic [7:0] pix_y,
    output logic [7:0] pix_c,
    output logic       pix_c_is_cr,
    output logic [9:0] pix_x,
    output logic [9:0] line,
    output logic       field,
    output logic       sof,
    output logic       eol,
    output logic       locked,
    output logic [7:0] err_count
);

    localparam logic [9:0] X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] LINE_MAX = 10'(MAX_LINES);

    logic trs_hit, trs_valid, trs_f, trs_v, trs_h;

    trs_detector u_trs (
        .clk       (clk),
        .rst_n     (rst_n),
        .td_data   (td_data),
        .trs_hit   (trs_hit),
        .trs_valid (trs_valid),
        .f         (trs_f),
        .v         (trs_v),
        .h         (trs_h)
    );

    dec_state_t state_q, state_d;
    logic [1:0] phase_q;
    logic [9:0] x_q;
    logic [9:0] line_cnt_q;
    logic       armed_q;
    logic       sof_pend_q;
    logic [7:0] cb_q, cr_q;

    logic sav_active, new_line, data_byte, emit, last_pix, err_inc;

    assign sav_active = trs_valid && !trs_h && !trs_v;
    assign new_line   = sav_active && (state_q != NOLOCK);
    // A valid XY byte is never pixel data; preamble bytes in ACTIVE are.
    assign data_byte  = (state_q == ACTIVE) && !trs_valid;
    assign emit       = data_byte && phase_q[0];
    assign last_pix   = emit && (x_q == X_LAST);
    assign err_inc    = (trs_hit && !trs_valid) || (trs_valid && (state_q == ACTIVE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NOLOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NOLOCK: if (trs_valid) state_d = BLANK;
            BLANK:  if (sav_active) state_d = ACTIVE;
            ACTIVE: begin
                if (trs_valid) state_d = sav_active ? ACTIVE : BLANK;
                else if (last_pix) state_d = BLANK;
            end
            default: state_d = NOLOCK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_y       <= '0;
            pix_c       <= '0;
            pix_c_is_cr <= 1'b0;
            pix_x       <= '0;
            line        <= '0;
            field       <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
            phase_q     <= '0;
            x_q         <= '0;
            line_cnt_q  <= '0;
            armed_q     <= 1'b0;
            sof_pend_q  <= 1'b0;
            cb_q        <= '0;
            cr_q        <= '0;
        end else begin
            pix_valid <= emit;
            sof       <= emit && sof_pend_q;
            eol       <= last_pix;
            line      <= line_cnt_q;

            if (trs_valid) begin
                field  <= trs_f;
                locked <= 1'b1;
                if (trs_v) armed_q <= 1'b1;
            end

            if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

            if (new_line) begin
                phase_q <= 2'd0;
                x_q     <= '0;
                if (armed_q) begin
                    line_cnt_q <= '0;
                    sof_pend_q <= 1'b1;
                    armed_q    <= 1'b0;
                end
            end else if (data_byte) begin
                phase_q <= phase_q + 2'd1;
                unique case (phase_q)
                    2'd0: cb_q <= td_data;
                    2'd2: cr_q <= td_data;
                    default: begin
                        // Phases 1 and 3 are Y bytes; phase_q[1] selects Cr.
                        pix_y       <= td_data;
                        pix_c       <= phase_q[1] ? cr_q : cb_q;
                        pix_c_is_cr <= phase_q[1];
                        pix_x       <= x_q;
                        x_q         <= x_q + 10'd1;
                        sof_pend_q  <= 1'b0;
                        if ((x_q == X_LAST) && (line_cnt_q != LINE_MAX))
                            line_cnt_q <= line_cnt_q + 10'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_itu656_decoder.sv
// Randomised self-checking bench for itu656_decoder against a line-level
// pixel model built from the byte stream it sends.
module tb_itu656_decoder;

    localparam int H = 720;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] td_data = 8'h00;
    logic       pix_valid, pix_c_is_cr, field, sof, eol, locked;
    logic [7:0] pix_y, pix_c, err_count;
    logic [9:0] pix_x, line;

    itu656_decoder #(.H_ACTIVE(H), .MAX_LINES(1023)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .td_data     (td_data),
        .pix_valid   (pix_valid),
        .pix_y       (pix_y),
        .pix_c       (pix_c),
        .pix_c_is_cr (pix_c_is_cr),
        .pix_x       (pix_x),
        .line        (line),
        .field       (field),
        .sof         (sof),
        .eol         (eol),
        .locked      (locked),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] c;
        logic       is_cr;
        logic [9:0] x;
        logic [9:0] ln;
        logic       fld;
        logic       sof;
        logic       eol;
    } pix_t;

    pix_t       obs_q[$];
    pix_t       exp_q[$];
    logic [7:0] data_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // The eight legal XY codes of BT.656, listed rather than derived.
    logic [7:0] good_xy [8] = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};

    int m_line, m_err;
    bit m_field, m_armed, m_locked, m_sof_pend;

    always @(negedge clk)
        if (pix_valid) obs_q.push_back(pix_t'({pix_y, pix_c, pix_c_is_cr, pix_x, line, field, sof, eol}));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_line = 0; m_err = 0; m_field = 0; m_armed = 0; m_locked = 0; m_sof_pend = 0;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic drive_byte(input logic [7:0] b);
        td_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_byte(8'($urandom_range(1, 254)));
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(1, 254)));
    endtask

    task automatic send_trs(input logic [7:0] xy);
        bit ok, was_locked;
        drive_byte(8'hFF); drive_byte(8'h00); drive_byte(8'h00); drive_byte(xy);
        ok = 0;
        foreach (good_xy[i]) if (good_xy[i] == xy) ok = 1;
        if (!ok) begin
            if (m_err < 255) m_err++;
            return;
        end
        was_locked = m_locked;
        m_locked   = 1;
        m_field    = xy[6];
        if (xy[5]) m_armed = 1;
        else if (!xy[4] && was_locked && m_armed) begin
            m_line = 0; m_sof_pend = 1; m_armed = 0;
        end
    endtask

    // SAV, contents of data_q, then the terminating TRS. A line of exactly 2*H
    // bytes is complete; anything shorter is cut off by the TRS preamble.
    task automatic play_line(input logic [7:0] sav, input logic [7:0] eav, input int gap);
        logic [7:0] s[$];
        bit start_sof, full;
        int n_pix;
        send_trs(sav);
        start_sof  = m_sof_pend;
        m_sof_pend = 0;
        foreach (data_q[i]) drive_byte(data_q[i]);
        full = (data_q.size() >= 2 * H);
        s = data_q;
        s.push_back(8'hFF); s.push_back(8'h00); s.push_back(8'h00);
        n_pix = full ? H : s.size() / 2;
        for (int j = 0; j < n_pix; j++)
            exp_q.push_back(pix_t'({s[2*j+1], s[4*(j/2) + 2*(j%2)], 1'(j % 2), 10'(j), 10'(m_line),
                                    m_field, (j == 0) && start_sof, full && (j == H - 1)}));
        if (full) begin
            if (m_line < 1023) m_line++;
        end else if (m_err < 255) m_err++;
        send_trs(eav);
        idle(gap);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pix_valid, sof, eol} !== 3'b000) begin
            n_bad++; $display("FAIL reset strobes: got %b want 000", {pix_valid, sof, eol});
        end
        n_cmp++;
        if ({pix_y, pix_c, pix_x, line} !== 36'h0) begin
            n_bad++; $display("FAIL reset data: got %h want 0", {pix_y, pix_c, pix_x, line});
        end
        n_cmp++;
        if ({locked, field, pix_c_is_cr} !== 3'b000) begin
            n_bad++; $display("FAIL reset flags: got %b want 000", {locked, field, pix_c_is_cr});
        end
        n_cmp++;
        if (err_count !== 8'd0) begin
            n_bad++; $display("FAIL reset err_count: got %0d want 0", err_count);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_corrupt_nolock();
        send_trs(8'h81);
        idle(20);
        n_cmp++;
        if (err_count !== 8'(m_err)) begin
            n_bad++; $display("FAIL corrupt err_count: got %0d want %0d", err_count, m_err);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++; $display("FAIL corrupt locked: got %b want 0", locked);
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL corrupt pixels: got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_one_line();
        send_trs(8'hB6);
        idle(8);
        fill_random(2 * H);
        play_line(8'h80, 8'h9D, 4);
        n_cmp++;
        if (obs_q.size() != H) begin
            n_bad++; $display("FAIL one_line count: got %0d want %0d", obs_q.size(), H);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL one_line pixel %0d: got %h want %h", i, obs_q[i], exp_q[i]);
                break;
            end
        end
        n_cmp++;
        if ({locked, line, err_count} !== {1'b1, 10'(m_line), 8'(m_err)}) begin
            n_bad++; $display("FAIL one_line after eol locked/line/err: got %b/%0d/%0d want 1/%0d/%0d",
                              locked, line, err_count, m_line, m_err);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_chroma();
        fill_random(2 * H);
        data_q[0] = 8'h10; data_q[1] = 8'h20; data_q[2] = 8'h30; data_q[3] = 8'h40;
        play_line(8'h80, 8'h9D, 4);
        n_cmp++;
        if (obs_q.size() < 2) begin
            n_bad++; $display("FAIL chroma count: got %0d want %0d", obs_q.size(), H);
        end else begin
            n_cmp++;
            if ({obs_q[0].y, obs_q[0].c, obs_q[0].is_cr, obs_q[1].y, obs_q[1].c, obs_q[1].is_cr}
                    !== {8'h20, 8'h10, 1'b0, 8'h40, 8'h30, 1'b1}) begin
                n_bad++; $display("FAIL chroma pair: got %h/%h/%b %h/%h/%b want 20/10/0 40/30/1",
                                  obs_q[0].y, obs_q[0].c, obs_q[0].is_cr, obs_q[1].y, obs_q[1].c, obs_q[1].is_cr);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL chroma pixel %0d: got %h want %h", i, obs_q[i], exp_q[i]);
                break;
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_field_change();
        send_trs(8'hF1);
        idle(10);
        fill_random(2 * H);
        play_line(8'hC7, 8'hDA, 4);
        n_cmp++;
        if (field !== 1'b1) begin
            n_bad++; $display("FAIL field_change field: got %b want 1", field);
        end
        n_cmp++;
        if (obs_q.size() == 0 || obs_q[0].sof !== 1'b1 || obs_q[0].ln !== 10'd0) begin
            n_bad++; $display("FAIL field_change first pixel sof/line: got %0d pixels want sof=1 line=0", obs_q.size());
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL field_change count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL field_change pixel %0d: got %h want %h", i, obs_q[i], exp_q[i]);
                break;
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_short_line();
        fill_random(198);
        play_line(8'hC7, 8'hDA, 4);
        n_cmp++;
        if (obs_q.size() != 100) begin
            n_bad++; $display("FAIL short_line count: got %0d want 100", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL short_line pixel %0d: got %h want %h", i, obs_q[i], exp_q[i]);
                break;
            end
        end
        n_cmp++;
        if (err_count !== 8'(m_err)) begin
            n_bad++; $display("FAIL short_line err_count: got %0d want %0d", err_count, m_err);
        end
        obs_q.delete(); exp_q.delete();
        idle(40);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL short_line blank pixels: got %0d want 0", obs_q.size());
        end
        fill_random(2 * H);
        play_line(8'hC7, 8'hDA, 4);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL short_line next count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL short_line next pixel %0d: got %h want %h", i, obs_q[i], exp_q[i]);
                break;
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_line();
        fill_random(2 * H);
        send_trs(8'hC7);
        for (int i = 0; i < 602; i++) drive_byte(data_q[i]);
        #1;
        n_cmp++;
        if ({pix_valid, pix_x} !== {1'b1, 10'd300}) begin
            n_bad++; $display("FAIL mid_line pre-reset pixel: got valid=%b x=%0d want 1/300", pix_valid, pix_x);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pix_valid, sof, eol, locked, field, pix_c_is_cr} !== 6'b0) begin
            n_bad++; $display("FAIL mid_line reset flags: got %b want 000000",
                              {pix_valid, sof, eol, locked, field, pix_c_is_cr});
        end
        n_cmp++;
        if ({pix_y, pix_c, pix_x, line, err_count} !== 44'h0) begin
            n_bad++; $display("FAIL mid_line reset data: got %h want 0", {pix_y, pix_c, pix_x, line, err_count});
        end
        #10;
        rst_n = 1'b1;
        model_reset();
        for (int i = 602; i < 2 * H; i++) drive_byte(data_q[i]);
        send_trs(8'h80);
        idle(200);
        n_cmp++;
        if ({obs_q.size() == 0, locked} !== 2'b11) begin
            n_bad++; $display("FAIL mid_line relock: got %0d pixels locked=%b want 0 pixels locked=1",
                              obs_q.size(), locked);
        end
        obs_q.delete();
        send_trs(8'hB6);
        idle(6);
        fill_random(2 * H);
        play_line(8'h80, 8'h9D, 4);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL mid_line resume count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL mid_line resume pixel %0d: got %h want %h", i, obs_q[i], exp_q[i]);
                break;
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        send_trs(8'hB6);
        for (int k = 0; k < 4; k++) begin
            fill_random(2 * H);
            play_line(8'h80, 8'h9D, $urandom_range(0, 3));
        end
        idle(4);
        n_cmp++;
        if (obs_q.size() != 4 * H) begin
            n_bad++; $display("FAIL back_to_back count: got %0d want %0d", obs_q.size(), 4 * H);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL back_to_back pixel %0d: got %h want %h", i, obs_q[i], exp_q[i]);
                break;
            end
        end
        n_cmp++;
        if ({line, err_count} !== {10'(m_line), 8'(m_err)}) begin
            n_bad++; $display("FAIL back_to_back line/err: got %0d/%0d want %0d/%0d", line, err_count, m_line, m_err);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_corrupt_nolock();
        test_one_line();
        test_chroma();
        test_field_change();
        test_short_line();
        test_reset_mid_line();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
